core_key_collector: RTL and testbench

//   Collects candidate keys reported by NUM_CORES parallel RC4 decryption cores.

---
 rtl/core_key_collector.sv | 99 +++++++++
 tb/tb_core_key_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_key_collector.sv
// Round-robin collector of candidate keys from parallel RC4 cores.
// Accepted {key, core index} pairs queue in a small FWFT FIFO that drains downstream.
module core_key_collector #(
  parameter int RAM_WIDTH     = 8,
  parameter int KEY_LENGTH    = 3,
  parameter int NUM_CORES     = 4,
  parameter int LOG_NUM_CORES = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic [NUM_CORES-1:0]                       req,
  input  logic [NUM_CORES-1:0][RAM_WIDTH*KEY_LENGTH-1:0] keys,
  output logic [NUM_CORES-1:0]                       grant,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [RAM_WIDTH*KEY_LENGTH-1:0]            out_key,
  output logic [LOG_NUM_CORES-1:0]                   out_core,
  output logic [$clog2(FIFO_DEPTH):0]                count,
  output logic                                       halted
);

  localparam int KW = RAM_WIDTH * KEY_LENGTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [KW-1:0]            mem_key  [FIFO_DEPTH];
  logic [LOG_NUM_CORES-1:0] mem_core [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [LOG_NUM_CORES-1:0] rr_ptr;

  logic                     found;
  logic [LOG_NUM_CORES-1:0] sel;
  int                       idx;
  logic [LOG_NUM_CORES-1:0] idx_l;
  logic                     full, accept, pop;

  // Scan from rr_ptr upward with an explicit modulo so non-power-of-2 core counts wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_l = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      idx_l = LOG_NUM_CORES'(idx);
      if (!found && req[idx_l]) begin
        found = 1'b1;
        sel   = idx_l;
      end
    end
  end

  // Handshake: the head transfers on any rising edge where out_valid and out_ready
  // are both high; out_valid never depends on out_ready.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign accept    = !reset && enable && !full && !halted && found;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_key   = mem_key[rd_ptr];
  assign out_core  = mem_core[rd_ptr];

  always_comb begin
    grant = '0;
    if (accept) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
      halted <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key[i]  <= '0;
        mem_core[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_key[wr_ptr]  <= keys[sel];
        mem_core[wr_ptr] <= sel;
        wr_ptr           <= wr_ptr + 1'b1;
        rr_ptr           <= (sel == LOG_NUM_CORES'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
        if (STOP_ON_FIRST != 0) halted <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_core_key_collector.sv
// Bench for core_key_collector: directed table, multi-cycle corner cases, and
// randomized traffic scored against a queue-based reference model.
module tb_core_key_collector;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance: 4 cores, free-running
  logic [3:0]       req4, grant4;
  logic [3:0][23:0] keys4;
  logic             en4, rdy4, ov4, halt4;
  logic [23:0]      key4;
  logic [1:0]       core4;
  logic [2:0]       cnt4;

  core_key_collector #(.NUM_CORES(4), .LOG_NUM_CORES(2), .FIFO_DEPTH(4), .STOP_ON_FIRST(0)) dut (
    .clk(clk), .reset(reset), .enable(en4), .req(req4), .keys(keys4), .grant(grant4),
    .out_valid(ov4), .out_ready(rdy4), .out_key(key4), .out_core(core4), .count(cnt4), .halted(halt4));

  // 3-core instance for modulo wrap
  logic [2:0]       req3, grant3;
  logic [2:0][23:0] keys3;
  logic             en3, rdy3, ov3, halt3;
  logic [23:0]      key3;
  logic [1:0]       core3;
  logic [2:0]       cnt3;

  core_key_collector #(.NUM_CORES(3), .LOG_NUM_CORES(2), .FIFO_DEPTH(4), .STOP_ON_FIRST(0)) dut3 (
    .clk(clk), .reset(reset), .enable(en3), .req(req3), .keys(keys3), .grant(grant3),
    .out_valid(ov3), .out_ready(rdy3), .out_key(key3), .out_core(core3), .count(cnt3), .halted(halt3));

  // Stop-on-first instance
  logic [3:0]       reqs, grants;
  logic [3:0][23:0] keyss;
  logic             ens, rdys, ovs, halts;
  logic [23:0]      keys_out;
  logic [1:0]       cores;
  logic [2:0]       cnts;

  core_key_collector #(.NUM_CORES(4), .LOG_NUM_CORES(2), .FIFO_DEPTH(4), .STOP_ON_FIRST(1)) duts (
    .clk(clk), .reset(reset), .enable(ens), .req(reqs), .keys(keyss), .grant(grants),
    .out_valid(ovs), .out_ready(rdys), .out_key(keys_out), .out_core(cores), .count(cnts), .halted(halts));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] key_of(input int i);
    return {8'hC0 + 8'(i), 8'(i * 17), 8'h5A};
  endfunction

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] g;
    int         cnt;
    int         core;   // -1: head not checked
  } vec_t;

  vec_t tbl[18];

  // Reference model state
  logic [25:0] exp_q[$];
  int          m_rr;
  logic [3:0]  m_req;
  logic [3:0][23:0] m_keys;

  initial begin
    reset = 1'b1;
    en4 = 1'b1; rdy4 = 1'b0; req4 = 4'hF;
    en3 = 1'b1; rdy3 = 1'b1; req3 = '0;
    ens = 1'b1; rdys = 1'b0; reqs = '0;
    for (int i = 0; i < 4; i++) begin
      keys4[i] = key_of(i);
      keyss[i] = 24'($urandom);
    end
    for (int i = 0; i < 3; i++) keys3[i] = key_of(i + 8);

    // Round-robin fill and drain, then backpressure with a single pop cycle
    tbl[0]  = '{4'hF, 1'b0, 4'h1, 0, -1};
    tbl[1]  = '{4'hE, 1'b0, 4'h2, 1, 0};
    tbl[2]  = '{4'hC, 1'b0, 4'h4, 2, 0};
    tbl[3]  = '{4'h8, 1'b0, 4'h8, 3, 0};
    tbl[4]  = '{4'h0, 1'b0, 4'h0, 4, 0};
    tbl[5]  = '{4'h0, 1'b1, 4'h0, 4, 0};
    tbl[6]  = '{4'h0, 1'b1, 4'h0, 3, 1};
    tbl[7]  = '{4'h0, 1'b1, 4'h0, 2, 2};
    tbl[8]  = '{4'h0, 1'b1, 4'h0, 1, 3};
    tbl[9]  = '{4'h0, 1'b0, 4'h0, 0, -1};
    tbl[10] = '{4'hF, 1'b0, 4'h1, 0, -1};
    tbl[11] = '{4'hE, 1'b0, 4'h2, 1, 0};
    tbl[12] = '{4'hC, 1'b0, 4'h4, 2, 0};
    tbl[13] = '{4'h8, 1'b0, 4'h8, 3, 0};
    tbl[14] = '{4'h3, 1'b0, 4'h0, 4, 0};
    tbl[15] = '{4'h3, 1'b1, 4'h0, 4, 0};
    tbl[16] = '{4'h3, 1'b0, 4'h1, 3, 1};
    tbl[17] = '{4'h2, 1'b0, 4'h0, 4, 1};

    // Reset held two cycles with all cores requesting
    tick(); tick();
    chk("reset_grant", 64'(grant4), 64'h0);
    chk("reset_valid", 64'(ov4), 64'h0);
    chk("reset_count", 64'(cnt4), 64'h0);
    chk("reset_key", 64'(key4), 64'h0);
    chk("reset_halted", 64'(halt4), 64'h0);
    reset = 1'b0;

    for (int r = 0; r < 18; r++) begin
      req4 = tbl[r].req;
      rdy4 = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_grant", r), 64'(grant4), 64'(tbl[r].g));
      chk($sformatf("tbl%0d_count", r), 64'(cnt4), 64'(tbl[r].cnt));
      chk($sformatf("tbl%0d_valid", r), 64'(ov4), 64'(tbl[r].cnt != 0));
      if (tbl[r].core >= 0) begin
        chk($sformatf("tbl%0d_core", r), 64'(core4), 64'(tbl[r].core));
        chk($sformatf("tbl%0d_key", r), 64'(key4), 64'(key_of(tbl[r].core)));
      end
      tick();
    end

    // Reset mid-operation with three entries queued
    req4 = 4'h0; rdy4 = 1'b1;
    tick();
    chk("mid_count3", 64'(cnt4), 64'd3);
    req4 = 4'hF; rdy4 = 1'b0; reset = 1'b1;
    #1;
    chk("mid_grant_in_reset", 64'(grant4), 64'h0);
    tick();
    chk("mid_count", 64'(cnt4), 64'h0);
    chk("mid_valid", 64'(ov4), 64'h0);
    chk("mid_key", 64'(key4), 64'h0);
    chk("mid_halted", 64'(halt4), 64'h0);
    reset = 1'b0;
    #1;
    chk("mid_first_grant", 64'(grant4), 64'h1);
    tick();
    chk("mid_first_key", 64'(key4), 64'(key_of(0)));
    req4 = 4'h0;

    // Three-core wrap: after core 2, lowest index wins again
    reset = 1'b1; tick(); reset = 1'b0;
    req3 = 3'b100; #1;
    chk("nc3_grant2", 64'(grant3), 64'h4);
    tick();
    chk("nc3_key2", 64'(key3), 64'(key_of(10)));
    req3 = 3'b101; #1;
    chk("nc3_grant0", 64'(grant3), 64'h1);
    tick();
    req3 = 3'b100; #1;
    chk("nc3_grant2b", 64'(grant3), 64'h4);
    tick();
    req3 = 3'b000;

    // Stop-on-first
    reset = 1'b1; tick(); reset = 1'b0;
    reqs = 4'b0100; keyss[2] = 24'hA5B6C7; #1;
    chk("sof_grant", 64'(grants), 64'h4);
    tick();
    reqs = 4'hF; #1;
    chk("sof_halted", 64'(halts), 64'h1);
    chk("sof_key", 64'(keys_out), 64'hA5B6C7);
    chk("sof_core", 64'(cores), 64'h2);
    for (int c = 0; c < 4; c++) begin
      rdys = (c == 2);
      #1;
      chk($sformatf("sof_nogrant%0d", c), 64'(grants), 64'h0);
      tick();
    end
    chk("sof_count_after_pop", 64'(cnts), 64'h0);
    chk("sof_still_halted", 64'(halts), 64'h1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("sof_unhalted", 64'(halts), 64'h0);
    chk("sof_regrant", 64'(grants), 64'h1);
    reqs = 4'h0;

    // Randomized traffic against the queue model
    reset = 1'b1; req4 = '0; tick(); reset = 1'b0;
    exp_q.delete();
    m_rr = 0;
    m_req = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int g;
      logic [3:0] exp_g;
      for (int i = 0; i < 4; i++)
        if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i]  = 1'b1;
          m_keys[i] = 24'($urandom);
        end
      req4  = m_req;
      keys4 = m_keys;
      en4   = ($urandom_range(0, 7) != 0);
      rdy4  = ($urandom_range(0, 2) != 0);
      #1;
      g = -1;
      if (en4 && exp_q.size() < 4)
        for (int k = 0; k < 4; k++)
          if (g < 0 && m_req[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      exp_g = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk("rnd_grant", 64'(grant4), 64'(exp_g));
      chk("rnd_count", 64'(cnt4), 64'(exp_q.size()));
      chk("rnd_valid", 64'(ov4), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("rnd_head", 64'({key4, core4}), 64'(exp_q[0]));
      tick();
      if (rdy4 && exp_q.size() != 0) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({m_keys[g], 2'(g)});
        m_rr = (g + 1) % 4;
        m_req[g] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
